// File: rtl/qdma_h2c_stream_checker_if.sv
// H2C AXI-Stream beat bundle: data with even byte parity, byte keep, 64-bit sideband.
// The master drives the beat and the slave drives tready.
interface qdma_h2c_stream_checker_if #(
   parameter int TDATA_W = 512
);
   localparam int BYTE_W = TDATA_W / 8;

   logic [TDATA_W-1:0] tdata;
   logic [BYTE_W-1:0]  tparity;
   logic [BYTE_W-1:0]  tkeep;
   logic [63:0]        tusr;
   logic               tlast;
   logic               tvalid;
   logic               tready;

   modport master (output tdata, tparity, tkeep, tusr, tlast, tvalid, input  tready);
   modport slave  (input  tdata, tparity, tkeep, tusr, tlast, tvalid, output tready);
endinterface

// File: rtl/qdma_h2c_stream_checker.sv
// H2C stream checker: 2-entry skid buffer forwarding beats unchanged, per-packet
// status record (qid, byte length, error flags) and wrapping packet/error counters.
module qdma_h2c_stream_checker #(
   parameter int TDATA_W = 512,
   parameter int LEN_W   = 16
) (
   input  logic                      user_clk,
   input  logic                      user_reset,
   qdma_h2c_stream_checker_if.slave  s,
   qdma_h2c_stream_checker_if.master m,
   output logic                      sts_valid,
   input  logic                      sts_ready,
   output logic [10:0]               sts_qid,
   output logic [LEN_W-1:0]          sts_len,
   output logic [5:0]                sts_flags,
   output logic [31:0]               pkt_cnt,
   output logic [31:0]               err_cnt
);
   localparam int BYTE_W = TDATA_W / 8;
   localparam int POP_W  = $clog2(BYTE_W + 1);
   localparam int SUM_W  = LEN_W + 1;
   localparam logic [LEN_W-1:0]  LEN_MAX  = '1;
   localparam logic [BYTE_W-1:0] KEEP_ONE = BYTE_W'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_IN_PKT, ST_REPORT} state_t;

   typedef struct packed {
      logic [TDATA_W-1:0] data;
      logic [BYTE_W-1:0]  parity;
      logic [BYTE_W-1:0]  keep;
      logic [63:0]        usr;
      logic               last;
   } beat_t;

   state_t             r_state;
   state_t             w_state_nx;
   beat_t              r_mem [2];
   beat_t              w_in_beat;
   beat_t              w_out_beat;
   logic               r_wr_ptr;
   logic               r_rd_ptr;
   logic [1:0]         r_count;
   logic               w_push;
   logic               w_pop;
   logic               w_sts_stall;
   logic               w_load;

   logic [10:0]        r_qid;
   logic [LEN_W-1:0]   r_len;
   logic [5:0]         r_flags;
   logic               r_sts_valid;
   logic [10:0]        r_sts_qid;
   logic [LEN_W-1:0]   r_sts_len;
   logic [5:0]         r_sts_flags;
   logic [31:0]        r_pkt_cnt;
   logic [31:0]        r_err_cnt;

   logic               w_first;
   logic               w_zb_single;
   logic [BYTE_W-1:0]  w_keep_eff;
   logic [POP_W-1:0]   w_pop_cnt;
   logic               w_par_err;
   logic               w_keep_contig;
   logic               w_keep_err;
   logic               w_qid_chg;
   logic [LEN_W-1:0]   w_len_base;
   logic [SUM_W-1:0]   w_len_sum;
   logic               w_len_ovf;
   logic [LEN_W-1:0]   w_len_next;
   logic [5:0]         w_flags_next;
   logic [10:0]        w_qid_next;

   // ---------------- skid buffer ----------------
   assign w_sts_stall = r_sts_valid && !sts_ready;
   assign s.tready    = !user_reset && (r_count < 2'd2) && !w_sts_stall;
   assign w_push      = s.tvalid && s.tready;
   assign w_pop       = m.tvalid && m.tready;
   assign w_in_beat   = {s.tdata, s.tparity, s.tkeep, s.tusr, s.tlast};

   // NOTE: flops use non-blocking <= so every register samples pre-edge values.
   always_ff @(posedge user_clk or posedge user_reset) begin
      if (user_reset) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage is not reset; an entry is only visible while r_count covers it.
   always_ff @(posedge user_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_in_beat;
   end

   assign w_out_beat = r_mem[r_rd_ptr];
   assign m.tdata    = w_out_beat.data;
   assign m.tparity  = w_out_beat.parity;
   assign m.tkeep    = w_out_beat.keep;
   assign m.tusr     = w_out_beat.usr;
   assign m.tlast    = w_out_beat.last;
   assign m.tvalid   = (r_count != 2'd0);

   // ---------------- per-beat checks ----------------
   assign w_first     = (r_state != ST_IN_PKT);
   assign w_zb_single = s.tusr[53] && s.tlast && w_first;
   assign w_keep_eff  = w_zb_single ? '0 : s.tkeep;
   assign w_pop_cnt   = POP_W'($countones(w_keep_eff));

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_par_err = 1'b0;
      for (int i = 0; i < BYTE_W; i++) begin
         if (w_keep_eff[i] && (s.tparity[i] != ^s.tdata[8*i +: 8])) w_par_err = 1'b1;
      end
   end

   // A last-beat keep is legal only as a run of ones starting at byte 0.
   assign w_keep_contig = ((s.tkeep & (s.tkeep + KEEP_ONE)) == '0);
   assign w_keep_err    = !w_zb_single &&
                          ((!s.tlast && !(&s.tkeep)) ||
                           (s.tlast && !w_keep_contig) ||
                           (s.tkeep == '0 && !s.tusr[53]) ||
                           s.tusr[53]);

   assign w_qid_chg    = !w_first && (s.tusr[10:0] != r_qid);
   assign w_qid_next   = w_first ? s.tusr[10:0] : r_qid;
   assign w_len_base   = w_first ? '0 : r_len;
   assign w_len_sum    = {1'b0, w_len_base} + SUM_W'(w_pop_cnt);
   assign w_len_ovf    = w_len_sum[LEN_W];
   assign w_len_next   = w_len_ovf ? LEN_MAX : w_len_sum[LEN_W-1:0];
   assign w_flags_next = (w_first ? 6'b0 : r_flags) |
                         {w_len_ovf, w_qid_chg, w_keep_err, w_par_err, s.tusr[14], w_zb_single};

   // ---------------- packet FSM ----------------
   always_ff @(posedge user_clk or posedge user_reset) begin
      if (user_reset) r_state <= ST_IDLE;
      else            r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_load     = w_push && s.tlast;
      case (r_state)
         ST_IDLE, ST_REPORT: begin
            // A pending record retires in the same cycle a new first beat is taken.
            if (w_push)                                 w_state_nx = s.tlast ? ST_REPORT : ST_IN_PKT;
            else if (r_state == ST_REPORT && sts_ready) w_state_nx = ST_IDLE;
         end
         ST_IN_PKT: if (w_load) w_state_nx = ST_REPORT;
         default:   w_state_nx = ST_IDLE;
      endcase
   end

   // ---------------- accumulators, status, counters ----------------
   always_ff @(posedge user_clk or posedge user_reset) begin
      if (user_reset) begin
         r_qid       <= '0;
         r_len       <= '0;
         r_flags     <= '0;
         r_sts_valid <= 1'b0;
         r_sts_qid   <= '0;
         r_sts_len   <= '0;
         r_sts_flags <= '0;
         r_pkt_cnt   <= '0;
         r_err_cnt   <= '0;
      end else begin
         if (w_push) begin
            r_qid   <= w_qid_next;
            r_len   <= w_len_next;
            r_flags <= w_flags_next;
         end
         if (w_load) begin
            r_sts_valid <= 1'b1;
            r_sts_qid   <= w_qid_next;
            r_sts_len   <= w_len_next;
            r_sts_flags <= w_flags_next;
            r_pkt_cnt   <= r_pkt_cnt + 32'd1;
            if (|w_flags_next[5:1]) r_err_cnt <= r_err_cnt + 32'd1;
         end else if (r_sts_valid && sts_ready) begin
            r_sts_valid <= 1'b0;
         end
      end
   end

   assign sts_valid = r_sts_valid;
   assign sts_qid   = r_sts_qid;
   assign sts_len   = r_sts_len;
   assign sts_flags = r_sts_flags;
   assign pkt_cnt   = r_pkt_cnt;
   assign err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_qdma_h2c_stream_checker.sv
// Directed bench for qdma_h2c_stream_checker: scoreboards forwarded beats and
// status records against a reference model of the packet checks.
module tb_qdma_h2c_stream_checker;
   typedef struct packed {
      logic [511:0] data;
      logic [63:0]  parity;
      logic [63:0]  keep;
      logic [63:0]  usr;
      logic         last;
   } beat_t;

   typedef struct packed {
      logic [10:0] qid;
      logic [15:0] len;
      logic [5:0]  flags;
   } sts_t;

   localparam logic [63:0] KEEP_ALL = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        user_clk   = 1'b0;
   logic        user_reset = 1'b0;
   logic        sts_ready;
   logic        sts_valid;
   logic [10:0] sts_qid;
   logic [15:0] sts_len;
   logic [5:0]  sts_flags;
   logic [31:0] pkt_cnt;
   logic [31:0] err_cnt;

   qdma_h2c_stream_checker_if s_if ();
   qdma_h2c_stream_checker_if m_if ();

   qdma_h2c_stream_checker #(.TDATA_W(512), .LEN_W(16)) dut (
      .user_clk   (user_clk),
      .user_reset (user_reset),
      .s          (s_if),
      .m          (m_if),
      .sts_valid  (sts_valid),
      .sts_ready  (sts_ready),
      .sts_qid    (sts_qid),
      .sts_len    (sts_len),
      .sts_flags  (sts_flags),
      .pkt_cnt    (pkt_cnt),
      .err_cnt    (err_cnt)
   );

   always #5 user_clk = ~user_clk;

   int          checks = 0;
   int          errors = 0;
   beat_t       pkt [$];
   beat_t       m_q [$];
   sts_t        s_q [$];
   logic [31:0] exp_pkt = '0;
   logic [31:0] exp_err = '0;
   beat_t       mon_exp_beat;
   beat_t       mon_got_beat;
   sts_t        mon_exp_sts;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_beat(input beat_t obs, input beat_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL m_beat: observed %h expected %h", obs, exp);
      end
   endtask

   // Scoreboard monitors sample at the falling edge, away from the active edge.
   always @(negedge user_clk) begin
      if (!user_reset && m_if.tvalid && m_if.tready) begin
         check("m_beat_expected", 64'(m_q.size() != 0), 64'd1);
         if (m_q.size() != 0) begin
            mon_exp_beat = m_q.pop_front();
            mon_got_beat = {m_if.tdata, m_if.tparity, m_if.tkeep, m_if.tusr, m_if.tlast};
            check_beat(mon_got_beat, mon_exp_beat);
         end
      end
      if (!user_reset && sts_valid && sts_ready) begin
         check("sts_expected", 64'(s_q.size() != 0), 64'd1);
         if (s_q.size() != 0) begin
            mon_exp_sts = s_q.pop_front();
            check("sts_record", 64'({sts_qid, sts_len, sts_flags}), 64'(mon_exp_sts));
         end
      end
   end

   task automatic add_beat(input logic [63:0] keep, input logic [10:0] qid, input logic err,
                           input logic zb, input logic last, input int flip);
      beat_t b;
      for (int w = 0; w < 16; w++) b.data[32*w +: 32] = $urandom;
      for (int i = 0; i < 64; i++) b.parity[i] = ^b.data[8*i +: 8];
      if (flip >= 0) b.parity[flip] = ~b.parity[flip];
      b.keep     = keep;
      b.usr      = {$urandom, $urandom};
      b.usr[10:0] = qid;
      b.usr[14]  = err;
      b.usr[53]  = zb;
      b.last     = last;
      pkt.push_back(b);
   endtask

   // Reference model of one whole packet in pkt[].
   task automatic expect_pkt();
      int          len;
      int          cnt;
      int          n;
      logic [5:0]  fl;
      logic [10:0] qid0;
      bit          zb_ok, gap, contig;
      beat_t       x;
      sts_t        r;
      len  = 0;
      fl   = '0;
      n    = pkt.size();
      qid0 = pkt[0].usr[10:0];
      for (int b = 0; b < n; b++) begin
         x      = pkt[b];
         zb_ok  = x.usr[53] && x.last && (n == 1);
         gap    = 1'b0;
         contig = 1'b1;
         cnt    = 0;
         if (zb_ok) fl[0] = 1'b1;
         else begin
            for (int i = 0; i < 64; i++) begin
               if (x.keep[i]) begin
                  cnt++;
                  if (gap) contig = 1'b0;
                  if (x.parity[i] != ^x.data[8*i +: 8]) fl[2] = 1'b1;
               end else gap = 1'b1;
            end
            if (!x.last && x.keep != KEEP_ALL)     fl[3] = 1'b1;
            if (x.last && !contig)                 fl[3] = 1'b1;
            if (x.keep == 64'd0 && !x.usr[53])     fl[3] = 1'b1;
            if (x.usr[53])                         fl[3] = 1'b1;
         end
         if (x.usr[14]) fl[1] = 1'b1;
         if (b > 0 && x.usr[10:0] != qid0) fl[4] = 1'b1;
         len += cnt;
         if (len > 65535) begin
            len   = 65535;
            fl[5] = 1'b1;
         end
      end
      r.qid   = qid0;
      r.len   = len[15:0];
      r.flags = fl;
      s_q.push_back(r);
      exp_pkt++;
      if (|fl[5:1]) exp_err++;
   endtask

   task automatic sync();
      @(posedge user_clk);
      #1;
   endtask

   task automatic drive_beat(input beat_t b);
      s_if.tdata   = b.data;
      s_if.tparity = b.parity;
      s_if.tkeep   = b.keep;
      s_if.tusr    = b.usr;
      s_if.tlast   = b.last;
      s_if.tvalid  = 1'b1;
   endtask

   // Called one step after a rising edge; returns one step after the accepting edge.
   task automatic wait_accept(input beat_t b);
      bit done;
      done = 1'b0;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge user_clk);
         if (s_if.tready === 1'b1) begin
            @(posedge user_clk);
            m_q.push_back(b);
            done = 1'b1;
         end
      end
      #1;
      s_if.tvalid = 1'b0;
      check("s_accept", 64'(done), 64'd1);
   endtask

   task automatic send_beat(input int idx);
      drive_beat(pkt[idx]);
      wait_accept(pkt[idx]);
   endtask

   task automatic send_all();
      expect_pkt();
      for (int i = 0; i < pkt.size(); i++) send_beat(i);
      pkt.delete();
   endtask

   task automatic settle_and_count(input string tag);
      repeat (4) @(negedge user_clk);
      check({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt);
      check({tag, "_err_cnt"}, err_cnt, exp_err);
      sync();
   endtask

   initial begin
      s_if.tdata   = '0;
      s_if.tparity = '0;
      s_if.tkeep   = '0;
      s_if.tusr    = '0;
      s_if.tlast   = 1'b0;
      s_if.tvalid  = 1'b0;
      m_if.tready  = 1'b1;
      sts_ready    = 1'b1;
      #1 user_reset = 1'b1;

      // Reset state
      repeat (3) @(negedge user_clk);
      check("rst_m_tvalid", m_if.tvalid, 0);
      check("rst_s_tready", s_if.tready, 0);
      check("rst_sts", 64'({sts_valid, sts_qid, sts_len, sts_flags}), 0);
      check("rst_cnt", {pkt_cnt, err_cnt}, 0);
      sync();
      user_reset = 1'b0;
      @(negedge user_clk);
      check("post_rst_s_tready", s_if.tready, 1);
      sync();

      // Clean 3-beat packet with 1-cycle data latency check
      add_beat(KEEP_ALL, 11'h005, 0, 0, 0, -1);
      add_beat(KEEP_ALL, 11'h005, 0, 0, 0, -1);
      add_beat(64'h0000_0000_0000_FFFF, 11'h005, 0, 0, 1, -1);
      expect_pkt();
      check("lat_m_tvalid_before", m_if.tvalid, 0);
      send_beat(0);
      check("lat_m_tvalid_1cyc", m_if.tvalid, 1);
      send_beat(1);
      send_beat(2);
      @(negedge user_clk);
      check("clean_sts_len", sts_len, 16'd144);
      pkt.delete();
      settle_and_count("clean");

      // Parity error on beat 2 byte 7
      add_beat(KEEP_ALL, 11'h011, 0, 0, 0, -1);
      add_beat(KEEP_ALL, 11'h011, 0, 0, 1, 7);
      send_all();
      settle_and_count("parity");

      // Zero-byte packet
      add_beat(64'd0, 11'h022, 0, 1, 1, -1);
      send_all();
      settle_and_count("zero_byte");

      // Backpressure on m-side, then status backpressure
      m_if.tready = 1'b0;
      for (int i = 0; i < 4; i++) add_beat(KEEP_ALL, 11'h007, 0, 0, (i == 3), -1);
      expect_pkt();
      send_beat(0);
      send_beat(1);
      drive_beat(pkt[2]);
      repeat (4) begin
         @(negedge user_clk);
         check("bp_s_tready_full", s_if.tready, 0);
      end
      sync();
      m_if.tready = 1'b1;
      @(negedge user_clk);
      check("bp_registered_ready", s_if.tready, 0);
      wait_accept(pkt[2]);
      sts_ready = 1'b0;
      send_beat(3);
      @(negedge user_clk);
      check("sts_hold_valid", sts_valid, 1);
      check("sts_hold_len", sts_len, 16'd256);
      repeat (3) begin
         @(negedge user_clk);
         check("sts_hold_s_tready", s_if.tready, 0);
      end
      sync();
      sts_ready = 1'b1;
      @(negedge user_clk);
      check("sts_release_s_tready", s_if.tready, 1);
      sync();
      check("sts_retired", sts_valid, 0);
      pkt.delete();
      settle_and_count("backpressure");

      // qid change on beat 2
      add_beat(KEEP_ALL, 11'h005, 0, 0, 0, -1);
      add_beat(KEEP_ALL, 11'h006, 0, 0, 1, -1);
      send_all();
      settle_and_count("qid_chg");

      // Non-last beat with partial keep
      add_beat(64'h7FFF_FFFF_FFFF_FFFF, 11'h033, 0, 0, 0, -1);
      add_beat(KEEP_ALL, 11'h033, 0, 0, 1, -1);
      send_all();
      settle_and_count("keep_err");

      // Sideband error bit
      add_beat(KEEP_ALL, 11'h044, 1, 0, 1, -1);
      send_all();
      settle_and_count("usr_err");

      // 1100-beat packet saturates the length
      for (int i = 0; i < 1100; i++) add_beat(KEEP_ALL, 11'h7FF, 0, 0, (i == 1099), -1);
      send_all();
      @(negedge user_clk);
      check("ovf_sts_len", sts_len, 16'hFFFF);
      sync();
      settle_and_count("len_ovf");

      // Reset in the middle of a 4-beat packet
      m_if.tready = 1'b0;
      for (int i = 0; i < 4; i++) add_beat(KEEP_ALL, 11'h00A, 0, 0, (i == 3), -1);
      send_beat(0);
      send_beat(1);
      user_reset = 1'b1;
      m_q.delete();
      pkt.delete();
      @(negedge user_clk);
      check("midrst_m_tvalid", m_if.tvalid, 0);
      check("midrst_s_tready", s_if.tready, 0);
      check("midrst_sts_valid", sts_valid, 0);
      check("midrst_cnt", {pkt_cnt, err_cnt}, 0);
      exp_pkt = '0;
      exp_err = '0;
      sync();
      user_reset  = 1'b0;
      m_if.tready = 1'b1;
      @(negedge user_clk);
      check("midrst_after_s_tready", s_if.tready, 1);
      check("midrst_after_m_tvalid", m_if.tvalid, 0);
      sync();
      add_beat(64'h0000_0000_0000_00FF, 11'h009, 0, 0, 1, -1);
      send_all();
      settle_and_count("after_rst");

      // Drain the scoreboards
      for (int n = 0; n < 50 && (m_q.size() != 0 || s_q.size() != 0); n++) @(negedge user_clk);
      check("m_q_drained", 64'(m_q.size()), 0);
      check("s_q_drained", 64'(s_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/qdma_h2c_stream_checker.md
# qdma_h2c_stream_checker

Register-sliced checking stage placed directly downstream of the CPM QDMA H2C AXI-Stream port in the user logic. It accepts 512-bit H2C beats with byte parity and a 64-bit sideband, forwards them unchanged through a 2-entry skid buffer, and produces one status record per packet. Each record carries the queue, the byte length and the error flags. It also keeps wrap-around packet and error counters for the example design's register file.

## Interface
Parameters:
- TDATA_W, 512, stream data width (fixed; 512 only)
- LEN_W, 16, packet length accumulator width

Ports:
- user_clk  in  1  sole clock
- user_reset  in  1  asynchronous, active-high reset
- s_tdata / s_tparity / s_tkeep / s_tusr  in  512 / 64 / 64 / 64  upstream H2C beat
- s_tlast, s_tvalid  in  1  upstream framing / valid
- s_tready  out  1  upstream ready
- m_tdata / m_tparity / m_tkeep / m_tusr / m_tlast / m_tvalid  out  as s_*  forwarded beat
- m_tready  in  1  downstream ready
- sts_valid  out  1  status record valid
- sts_ready  in  1  status consumer ready
- sts_qid  out  11  qid of the packet
- sts_len  out  16  accepted byte count (saturating)
- sts_flags  out  6  {len_ovf, qid_chg, keep_err, par_err, usr_err, zero_byte}
- pkt_cnt, err_cnt  out  32  packets / packets with any flag[5:1] set; both wrap

Sideband fields used:
- tusr[10:0]: qid
- tusr[14]: err
- tusr[53]: zero_byte
- All other bits are passed through untouched.

## Operation
- **Skid buffer:** 2-entry FIFO, in order.
  - An input beat is accepted when s_tvalid && s_tready.
  - An output beat transfers when m_tvalid && m_tready.
  - s_tready = (occupancy < 2) && !(sts_valid && !sts_ready).
  - m_tvalid = (occupancy != 0).
- **Checks** are performed on each accepted input beat, byte i = 0..63, and only where s_tkeep[i] = 1:
  - par_err if s_tparity[i] != ^s_tdata[8i+7:8i] (even parity).
  - keep_err if s_tkeep is not all-ones on a non-last beat.
  - keep_err if s_tkeep is not contiguous from bit 0 on a last beat.
  - keep_err if s_tkeep = 0 on any beat without zero_byte.
- **Packet FSM:**
  - IDLE: the first accepted beat latches qid, clears the flags, and sets len = popcount(s_tkeep).
    - If s_tlast is low, go to IN_PKT.
    - If s_tlast is high, go to REPORT.
  - IN_PKT: each beat adds popcount to len and ORs in the flags.
    - qid_chg is set if the beat's qid differs from the latched qid.
    - On s_tlast, go to REPORT.
  - REPORT: the status register is loaded, sts_valid = 1, pkt_cnt increments, and err_cnt increments if any of flags[5:1] is set.
    - If sts_ready is already high on the load cycle, the record retires the next cycle.
    - Otherwise sts_valid holds and input stalls via s_tready.
    - Returns to IDLE.
- **Length arithmetic:** popcount is 0..64; len is LEN_W bits and saturates at 0xFFFF with len_ovf set.
- **zero_byte beat:** must be a single beat with s_tlast. It reports len = 0 and flag zero_byte, and tkeep is ignored.
  - zero_byte without s_tlast sets keep_err and is otherwise treated as a normal beat.
- **usr_err:** OR of tusr[14] over all beats of the packet.
- **Data path:** beats are forwarded even when errors are detected; the block never drops or modifies beats.

## Timing
- **Reset values:** m_tvalid = 0, s_tready = 0 while user_reset is asserted.
  - s_tready = 1 from the first cycle after deassert.
  - sts_valid = 0, all sts_* = 0, pkt_cnt = err_cnt = 0, occupancy = 0, FSM in IDLE.
- **Data latency:** input beat to m_tvalid is 1 cycle when the FIFO is empty. Throughput is 1 beat/cycle with m_tready held high.
- **Status latency:** sts_valid rises the cycle after the tlast beat is accepted on s_*, independent of the m-side drain.
- **Back-to-back packets:**
  - A new packet's first beat may be accepted in the same cycle the previous record is loaded.
  - While sts_valid && !sts_ready, no beat is accepted.
- **Simultaneous events:**
  - With occupancy = 2, s_tready = 0 even if m_tready = 1 that cycle (registered-ready skid).
  - An input and an output transfer in the same cycle leave occupancy unchanged.
- **Mid-operation reset:** reset asserted mid-packet discards buffered beats and the partial packet, and no status is emitted.
- **Wrap:** counters wrap 0xFFFFFFFF -> 0.

## Test plan
- **Single clean packet:** 3 beats, qid 0x05, keep all-ones, all-ones, 0x0000_0000_0000_FFFF, correct parity -> sts_len = 144, flags = 0, pkt_cnt = 1, m-side beats identical, 1-cycle latency.
- **Parity error:** flip tparity[7] on beat 2 of a 2-beat 128-byte packet -> par_err = 1, sts_len = 128, err_cnt = 1, data forwarded unchanged.
- **Zero-byte packet:** single beat with zero_byte = 1, tkeep = 0 -> sts_len = 0, flags = 6'b000001, err_cnt unchanged.
- **Backpressure:** hold m_tready = 0 for 5 cycles during a 4-beat stream -> s_tready drops after 2 accepted beats, no loss or reorder. Hold sts_ready = 0 -> s_tready = 0 until the record is taken.
- **Protocol errors:** qid changes 0x05 -> 0x06 on beat 2 -> qid_chg. Non-last beat with tkeep = 0x7FFF... -> keep_err. A 1100-beat packet -> sts_len = 0xFFFF with len_ovf.
- **Reset mid-packet:** assert user_reset after beat 2 of 4 -> no status, counters 0, m_tvalid = 0; the next clean 1-beat packet reports correctly.
